// File: rtl/win5_col_gen_pkg.sv
// Shared image-pipeline definitions: default frame geometry, pixel width and
// the counter-width helper used by the window/filter blocks.
package win5_col_gen_pkg;
   localparam int IMG_WIDTH_DEF  = 640;
   localparam int IMG_HEIGHT_DEF = 480;
   localparam int DATA_W_DEF     = 8;
   localparam int WIN_ROWS       = 5;
   localparam int NUM_LBUF       = WIN_ROWS - 1;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/win5_linebuf.sv
// One line of pixel storage: simple dual-port RAM, synchronous read,
// read-before-write on a shared address. Contents are never reset.
module win5_linebuf #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/win5_col_gen.sv
// 5-row vertical column window generator: four chained line buffers feed a
// registered window with top-of-frame row clamping, 2-cycle latency.
module win5_col_gen
   import win5_col_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fs_in,
   input  logic              den_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic [DATA_W-1:0] data_out4,
   output logic              den_out
);
   localparam int CW     = cnt_w(IMG_WIDTH);
   localparam int RW     = cnt_w(IMG_HEIGHT);
   localparam int STAGES = 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col_q, col_d, col_cur, col1_q;
   logic [RW-1:0] row_q, row_d, row_cur, row1_q;
   logic [DATA_W-1:0] pix1_q, row0_v;
   logic [STAGES:1] vld_pipe_q;

   logic [NUM_LBUF-1:0][DATA_W-1:0] rd, wd;
   logic [WIN_ROWS-1:0][DATA_W-1:0] tap, win_d, win_q;

   // Frame start overrides the counters for the pixel it arrives with.
   always_comb begin
      col_cur = fs_in ? '0 : col_q;
      row_cur = fs_in ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (den_in) begin
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         vld_pipe_q <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], den_in};
      end
   end

   always_ff @(posedge clk) begin
      if (den_in) begin
         pix1_q <= data_in;
         col1_q <= col_cur;
         row1_q <= row_cur;
      end
   end

   // Chain: buffer j holds row y-1-j; each write lands one cycle after its read.
   always_comb begin
      wd[0]              = pix1_q;
      wd[NUM_LBUF-1:1]   = rd[NUM_LBUF-2:0];
   end

   for (genvar j = 0; j < NUM_LBUF; j++) begin : g_lbuf
      win5_linebuf #(
         .DEPTH  (IMG_WIDTH),
         .DATA_W (DATA_W),
         .AW     (CW)
      ) u_lbuf (
         .clk     (clk),
         .we_i    (vld_pipe_q[1]),
         .waddr_i (col1_q),
         .wdata_i (wd[j]),
         .re_i    (den_in),
         .raddr_i (col_cur),
         .rdata_o (rd[j])
      );
   end

   // Taps above the frame top repeat the row-0 pixel, so stale RAM never leaks.
   always_comb begin
      tap = {pix1_q, rd[0], rd[1], rd[2], rd[3]};
      case (row1_q[1:0])
         2'd0:    row0_v = pix1_q;
         2'd1:    row0_v = rd[0];
         2'd2:    row0_v = rd[1];
         default: row0_v = rd[2];
      endcase
      win_d = '0;
      for (int k = 0; k < WIN_ROWS; k++)
         win_d[k] = (int'(row1_q) >= (WIN_ROWS - 1 - k)) ? tap[k] : row0_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              win_q <= '0;
      else if (vld_pipe_q[1])  win_q <= win_d;
   end

   assign data_out0 = win_q[0];
   assign data_out1 = win_q[1];
   assign data_out2 = win_q[2];
   assign data_out3 = win_q[3];
   assign data_out4 = win_q[4];
   assign den_out   = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_win5_col_gen.sv
// Scoreboard bench for win5_col_gen on an 8x6 image with pixel = 16*y+x.
module tb_win5_col_gen;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 8;

   logic clk = 1'b0, rst_n = 1'b0, fs_in = 1'b0, den_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] d0, d1, d2, d3, d4;
   logic den_out;

   typedef struct {
      logic [4:0][7:0] w;
      int              t;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int cyc = 0, pass_cnt = 0, tot_cnt = 0, den_cnt = 0, den_base = 0;

   win5_col_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .fs_in(fs_in), .den_in(den_in), .data_in(data_in),
      .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3), .data_out4(d4),
      .den_out(den_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && den_out) begin
         den_cnt++;
         if (q.size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_den_out at cycle %0d: window %h", cyc, {d4, d3, d2, d1, d0});
         end else begin
            me = q.pop_front();
            chk("window", {d4, d3, d2, d1, d0}, me.w);
            chk("latency", 40'(cyc), 40'(me.t));
         end
      end
   end

   task automatic send(input logic fs, input logic [7:0] v, input logic [4:0][7:0] ew);
      exp_t e;
      @(negedge clk);
      fs_in = fs; den_in = 1'b1; data_in = v;
      e.w = ew; e.t = cyc + 2;
      q.push_back(e);
   endtask

   // Idle cycles; fs_in may toggle here and must be ignored.
   task automatic idle(input int n, input bit fs_noise);
      repeat (n) begin
         @(negedge clk);
         den_in = 1'b0;
         fs_in = fs_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         data_in = 8'($urandom);
      end
   endtask

   task automatic send_frame(input bit fs, input bit gaps, input int npix);
      logic [4:0][7:0] ew;
      int n = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            if (n == npix) return;
            if (gaps) idle($urandom_range(0, 2), 1'b1);
            for (int k = 0; k < 5; k++)
               ew[k] = 8'(16 * ((y - 4 + k < 0) ? 0 : (y - 4 + k)) + x);
            send(fs && n == 0, 8'(16 * y + x), ew);
            n++;
         end
   endtask

   initial begin
      #12;
      chk("reset_data", {d4, d3, d2, d1, d0}, 40'h0);
      chk("reset_den", 40'(den_out), 40'h0);
      @(negedge clk); rst_n = 1'b1;

      send_frame(1'b1, 1'b0, 48);                  // continuous frame
      idle(3, 1'b0);
      den_base = den_cnt;
      send_frame(1'b1, 1'b1, 48);                  // gapped frame
      idle(4, 1'b1);
      chk("den_count_frame", 40'(den_cnt - den_base), 40'd48);
      send_frame(1'b0, 1'b0, 48);                  // wrap into next frame, no fs
      idle(3, 1'b0);

      send_frame(1'b1, 1'b0, 20);                  // truncated frame, realign
      send(1'b1, 8'hA5, {5{8'hA5}});
      send(1'b0, 8'h3C, {5{8'h3C}});
      idle(3, 1'b0);
      send_frame(1'b1, 1'b1, 48);
      idle(3, 1'b0);

      send_frame(1'b1, 1'b0, 29);                  // stops after (4,3)
      @(negedge clk); den_in = 1'b0; fs_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_data", {d4, d3, d2, d1, d0}, 40'h0);
      chk("midreset_den", 40'(den_out), 40'h0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(1'b0, 8'h77, {5{8'h77}});
      idle(3, 1'b0);
      send_frame(1'b1, 1'b0, 48);
      idle(3, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         tot_cnt++;
         $display("FAIL drain_timeout: %0d windows outstanding, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
